stopwatch_counter: RTL
======================

Name: stopwatch_counter

Overview:
- Upstream time-keeping stage for seven_seg_display: holds the MM:SS stopwatch value as BCD digits and drives min1/min0/sec1/sec0 plus the blink request.
- Counts on a 1 Hz tick. Supports pause and resume, and an adjust mode that steps the minutes or seconds field at 2 Hz.
- Ticks are produced by the clock-divider block as single-cycle enables on clk. All logic runs in the clk domain.

Parameters:
- HOLD_AT_MAX, default 0: 0 means 59:59 wraps to 00:00 on the next 1 Hz tick; 1 means the count saturates at 59:59.

Ports:
- clk  input  1  system clock; single clock domain, rising edge
- rst_n  input  1  synchronous, active-low reset (sampled on rising clk)
- tick_1hz  input  1  one-cycle count enable, 1 Hz
- tick_2hz  input  1  one-cycle adjust-step enable, 2 Hz
- pause_btn  input  1  debounced and synchronised pause button level; each rising edge toggles pause
- adj  input  1  level; 1 selects adjust mode
- sel  input  1  level, used only in adjust mode; 0 steps minutes, 1 steps seconds
- sec0  output  4  seconds ones digit, BCD 0-9
- sec1  output  3  seconds tens digit, 0-5
- min0  output  4  minutes ones digit, BCD 0-9
- min1  output  3  minutes tens digit, 0-5
- blink  output  1  request to blink the display; equals registered adj
- paused  output  1  1 while counting is paused

Behaviour:
- Reset (rst_n=0 at a rising clk):
  - all digits 0, blink=0, paused=0 (the block comes out of reset running)
  - pause edge register loaded with 1, so a button held through reset does not toggle pause on release
- All outputs are registered and change one clk after the qualifying tick or edge.
- Pause edge: pause_edge = pause_btn & ~pause_q, with pause_q <= pause_btn every cycle. Each edge toggles paused in every mode, including adjust.
- Mode per cycle, evaluated from the current (pre-update) registers and inputs:
  - ADJUST when adj=1
  - else PAUSED when paused=1
  - else RUN
- RUN, on tick_1hz, BCD increment with carries:
  - sec0 9->0 carries to sec1
  - sec1 5 with sec0 9 -> seconds 00, carry to min0
  - min0 9->0 carries to min1
  - at 59:59: HOLD_AT_MAX=0 gives 00:00; HOLD_AT_MAX=1 holds 59:59
- PAUSED: digits hold; tick_1hz and tick_2hz are ignored.
- ADJUST:
  - tick_1hz is ignored
  - on tick_2hz the field chosen by sel increments by 1 mod 60 (59->00) with no carry into the other field
  - digits of the unselected field hold
  - sel is sampled in the same cycle as tick_2hz
- Leaving adjust (adj 1->0): resumes RUN or PAUSED according to paused. No count catch-up; ticks seen during adjust are lost.
- Simultaneous events:
  - pause_edge together with tick_1hz: the tick is applied under the pre-toggle mode (a running counter counts once, then pauses)
  - tick_1hz together with tick_2hz in ADJUST: only the adjust step applies
  - adj rising in the same cycle as tick_1hz: ADJUST wins and no count happens
- Reset mid-operation: reset in any mode returns to the reset values on the next edge; no residual adjust or pause state remains.
- Invariant: outputs never leave the BCD ranges above (digits >9, or tens >5, are unreachable).

Optional Feature:
- Macro: STOPWATCH_LAP_EN
- Defined:
  - adds port lap_btn (input, 1 bit; debounced and synchronised)
  - each rising edge of lap_btn toggles the lap flag
  - while lap=1, sec0/sec1/min0/min1 show the value captured at the toggle edge; the internal count keeps running, pausing and adjusting unaffected
  - toggling lap back to 0 shows the live value on the next cycle
  - reset clears lap, and lap_btn edge detection uses the same reset-to-1 rule as pause_btn
- Undefined: no lap_btn port, no capture registers; outputs always show the live count.

Test Plan:
- Reset then 61 tick_1hz pulses, no other input -> digits 01:01, paused=0, blink=0.
- Preload 09:59, one tick_1hz -> 10:00; preload 59:59, one tick_1hz -> 00:00 with HOLD_AT_MAX=0, 59:59 with HOLD_AT_MAX=1.
- At 00:05, pulse pause_btn in the same cycle as tick_1hz -> 00:06 and paused=1; 10 more ticks -> still 00:06; second pause edge, then 1 tick -> 00:07.
- adj=1, sel=1 at 00:58, 3 tick_2hz pulses -> 00:01 with minutes unchanged and blink=1; sel=0, 2 tick_2hz -> 02:01; tick_1hz pulses in between -> no change.
- pause_btn held high across reset release -> paused stays 0; release and press -> paused=1.
- With STOPWATCH_LAP_EN: lap edge at 00:10, then 5 ticks -> outputs show 00:10; second lap edge -> 00:15.

Source files
------------

// File: rtl/stopwatch_counter_if.sv
// Control inputs and BCD display outputs of stopwatch_counter.
// STOPWATCH_LAP_EN adds the lap_btn input.
interface stopwatch_counter_if;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       pause_btn;
  logic       adj;
  logic       sel;
`ifdef STOPWATCH_LAP_EN
  logic       lap_btn;
`endif
  logic [3:0] sec0;
  logic [2:0] sec1;
  logic [3:0] min0;
  logic [2:0] min1;
  logic       blink;
  logic       paused;

  modport master (
    output tick_1hz, tick_2hz, pause_btn, adj, sel,
`ifdef STOPWATCH_LAP_EN
    output lap_btn,
`endif
    input  sec0, sec1, min0, min1, blink, paused
  );

  modport slave (
    input  tick_1hz, tick_2hz, pause_btn, adj, sel,
`ifdef STOPWATCH_LAP_EN
    input  lap_btn,
`endif
    output sec0, sec1, min0, min1, blink, paused
  );
endinterface

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch with pause and 2 Hz field adjust; outputs registered, one clk after tick/edge.
// Optional lap hold behind STOPWATCH_LAP_EN; no backpressure, ticks are single-cycle enables.
module stopwatch_counter #(
  parameter bit HOLD_AT_MAX = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  stopwatch_counter_if.slave sw
);

  logic [3:0] sec0_r, sec0_n, min0_r, min0_n;
  logic [2:0] sec1_r, sec1_n, min1_r, min1_n;
  logic       paused_r, blink_r, pause_q;
  logic       pause_edge, sec_max, min_max;

  // Field increment mod 60, result packed as {tens, ones}.
  function automatic logic [6:0] inc60(input logic [2:0] tens, input logic [3:0] ones);
    if (ones == 4'd9)
      return (tens == 3'd5) ? 7'd0 : {tens + 3'd1, 4'd0};
    else
      return {tens, ones + 4'd1};
  endfunction

  assign pause_edge = sw.pause_btn & ~pause_q;
  assign sec_max    = (sec1_r == 3'd5) && (sec0_r == 4'd9);
  assign min_max    = (min1_r == 3'd5) && (min0_r == 4'd9);

  always_comb begin
    sec0_n = sec0_r;
    sec1_n = sec1_r;
    min0_n = min0_r;
    min1_n = min1_r;
    if (sw.adj) begin
      if (sw.tick_2hz) begin
        if (sw.sel) {sec1_n, sec0_n} = inc60(sec1_r, sec0_r);
        else        {min1_n, min0_n} = inc60(min1_r, min0_r);
      end
    end else if (!paused_r && sw.tick_1hz) begin
      if (!(HOLD_AT_MAX && sec_max && min_max)) begin
        {sec1_n, sec0_n} = inc60(sec1_r, sec0_r);
        if (sec_max) {min1_n, min0_n} = inc60(min1_r, min0_r);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sec0_r   <= 4'd0;
      sec1_r   <= 3'd0;
      min0_r   <= 4'd0;
      min1_r   <= 3'd0;
      paused_r <= 1'b0;
      blink_r  <= 1'b0;
      pause_q  <= 1'b1;
    end else begin
      sec0_r   <= sec0_n;
      sec1_r   <= sec1_n;
      min0_r   <= min0_n;
      min1_r   <= min1_n;
      paused_r <= paused_r ^ pause_edge;
      blink_r  <= sw.adj;
      pause_q  <= sw.pause_btn;
    end
  end

  assign sw.blink  = blink_r;
  assign sw.paused = paused_r;

`ifdef STOPWATCH_LAP_EN
  logic       lap_r, lap_q;
  logic [3:0] cap_sec0, cap_min0;
  logic [2:0] cap_sec1, cap_min1;
  logic       lap_edge;

  assign lap_edge = sw.lap_btn & ~lap_q;

  // Capture the pre-update count so the held value matches the toggle edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lap_r    <= 1'b0;
      lap_q    <= 1'b1;
      cap_sec0 <= 4'd0;
      cap_sec1 <= 3'd0;
      cap_min0 <= 4'd0;
      cap_min1 <= 3'd0;
    end else begin
      lap_q <= sw.lap_btn;
      lap_r <= lap_r ^ lap_edge;
      if (lap_edge && !lap_r) begin
        cap_sec0 <= sec0_r;
        cap_sec1 <= sec1_r;
        cap_min0 <= min0_r;
        cap_min1 <= min1_r;
      end
    end
  end

  assign sw.sec0 = lap_r ? cap_sec0 : sec0_r;
  assign sw.sec1 = lap_r ? cap_sec1 : sec1_r;
  assign sw.min0 = lap_r ? cap_min0 : min0_r;
  assign sw.min1 = lap_r ? cap_min1 : min1_r;
`else
  assign sw.sec0 = sec0_r;
  assign sw.sec1 = sec1_r;
  assign sw.min0 = min0_r;
  assign sw.min1 = min1_r;
`endif

endmodule
